// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, default widths and
// the flow-control characters used by the XON/XOFF source.
package uart_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_GUARD_W = 8;
    localparam int DEF_FCNT_W  = 16;

    localparam logic [7:0] XON  = 8'h11;
    localparam logic [7:0] XOFF = 8'h13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        START   = 3'd2,
        WAIT_FI = 3'd3,
        GUARD   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/uart_guard_timer.sv
// Inter-frame guard timer: loads a tick count, decrements on baud ticks and
// flags the tick that takes the count from 1 to 0.
module uart_guard_timer #(
    parameter int GUARD_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [GUARD_W-1:0] load_val_i,
    input  logic               tick_i,
    output logic               done_o
);

    logic [GUARD_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - GUARD_W'(1);
        end
    end

    // Expiry is the terminating tick itself, so the FSM leaves GUARD on it.
    assign done_o = tick_i && !load_i && (count_q == GUARD_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame scheduler: arbitrates control characters over FIFO data, sequences
// one transmitter frame at a time and enforces the inter-frame guard time.
//
// state   | meaning
// IDLE    | waiting for an eligible source
// GRANT   | byte latched, ack/pop pulse to the winning source
// START   | start pulse to the transmitter
// WAIT_FI | frame on the wire, waiting for frame-finish
// GUARD   | counting guard ticks before the next grant
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int GUARD_W = DEF_GUARD_W,
    parameter int FCNT_W  = DEF_FCNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_en_i,
    input  logic               cts_n_i,
    input  logic               tick_i,
    input  logic [GUARD_W-1:0] guard_cfg_i,
    input  logic               ctrl_req_i,
    input  logic [DATA_W-1:0]  ctrl_data_i,
    output logic               ctrl_ack,
    input  logic               fifo_empty_i,
    input  logic [DATA_W-1:0]  fifo_data_i,
    output logic               fifo_rd_en,
    output logic [DATA_W-1:0]  tx_data,
    output logic               start_tx,
    input  logic               trans_fi_i,
    output logic               busy,
    output logic               src_ctrl,
    output logic [FCNT_W-1:0]  frame_cnt
);

    sched_state_t       state_d, state_q;
    logic [DATA_W-1:0]  tx_data_d, tx_data_q;
    logic               src_ctrl_d, src_ctrl_q;
    logic [FCNT_W-1:0]  frame_cnt_d, frame_cnt_q;
    logic               ctrl_ack_d, ctrl_ack_q;
    logic               fifo_rd_en_d, fifo_rd_en_q;
    logic               start_tx_d, start_tx_q;
    logic               busy_d, busy_q;

    logic               elig_ctrl;
    logic               elig_fifo;
    logic               guard_load;
    logic               guard_done;

    assign elig_ctrl = tx_en_i && ctrl_req_i;
    assign elig_fifo = tx_en_i && !fifo_empty_i && !cts_n_i;

    uart_guard_timer #(
        .GUARD_W (GUARD_W)
    ) u_guard (
        .clk        (clk),
        .reset      (reset),
        .load_i     (guard_load),
        .load_val_i (guard_cfg_i),
        .tick_i     (tick_i),
        .done_o     (guard_done)
    );

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        src_ctrl_d  = src_ctrl_q;
        frame_cnt_d = frame_cnt_q;
        guard_load  = 1'b0;

        case (state_q)
            IDLE: begin
                // Control characters win ties so XOFF is never stuck behind data.
                if (elig_ctrl) begin
                    state_d    = GRANT;
                    tx_data_d  = ctrl_data_i;
                    src_ctrl_d = 1'b1;
                end else if (elig_fifo) begin
                    state_d    = GRANT;
                    tx_data_d  = fifo_data_i;
                    src_ctrl_d = 1'b0;
                end
            end
            GRANT:   state_d = START;
            START:   state_d = WAIT_FI;
            WAIT_FI: begin
                if (trans_fi_i) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    if (guard_cfg_i == '0) begin
                        state_d = IDLE;
                    end else begin
                        guard_load = 1'b1;
                        state_d    = GUARD;
                    end
                end
            end
            GUARD: begin
                if (guard_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ctrl_ack_d   = (state_d == GRANT) && src_ctrl_d;
        fifo_rd_en_d = (state_d == GRANT) && !src_ctrl_d;
        start_tx_d   = (state_d == START);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            src_ctrl_q   <= 1'b0;
            frame_cnt_q  <= '0;
            ctrl_ack_q   <= 1'b0;
            fifo_rd_en_q <= 1'b0;
            start_tx_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            src_ctrl_q   <= src_ctrl_d;
            frame_cnt_q  <= frame_cnt_d;
            ctrl_ack_q   <= ctrl_ack_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            start_tx_q   <= start_tx_d;
            busy_q       <= busy_d;
        end
    end

    assign ctrl_ack   = ctrl_ack_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign start_tx   = start_tx_q;
    assign busy       = busy_q;
    assign tx_data    = tx_data_q;
    assign src_ctrl   = src_ctrl_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a table of single-frame arbitration
// vectors followed by hand-written multi-cycle sequences.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_en_i, cts_n_i, tick_i;
    logic [7:0]  guard_cfg_i;
    logic        ctrl_req_i;
    logic [7:0]  ctrl_data_i;
    logic        ctrl_ack;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        start_tx;
    logic        trans_fi_i;
    logic        busy;
    logic        src_ctrl;
    logic [15:0] frame_cnt;

    logic        w_tx_en;
    logic        w_ctrl_ack, w_fifo_rd_en, w_start_tx, w_busy, w_src_ctrl;
    logic [7:0]  w_tx_data;
    logic [3:0]  w_frame_cnt;

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tx_en_i      (tx_en_i),
        .cts_n_i      (cts_n_i),
        .tick_i       (tick_i),
        .guard_cfg_i  (guard_cfg_i),
        .ctrl_req_i   (ctrl_req_i),
        .ctrl_data_i  (ctrl_data_i),
        .ctrl_ack     (ctrl_ack),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_en   (fifo_rd_en),
        .tx_data      (tx_data),
        .start_tx     (start_tx),
        .trans_fi_i   (trans_fi_i),
        .busy         (busy),
        .src_ctrl     (src_ctrl),
        .frame_cnt    (frame_cnt)
    );

    // Narrow frame counter so the wrap boundary is reachable in a short run.
    uart_tx_scheduler #(.FCNT_W(4)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .tx_en_i      (w_tx_en),
        .cts_n_i      (1'b0),
        .tick_i       (1'b0),
        .guard_cfg_i  (8'h00),
        .ctrl_req_i   (1'b0),
        .ctrl_data_i  (8'h00),
        .ctrl_ack     (w_ctrl_ack),
        .fifo_empty_i (1'b0),
        .fifo_data_i  (8'h5A),
        .fifo_rd_en   (w_fifo_rd_en),
        .tx_data      (w_tx_data),
        .start_tx     (w_start_tx),
        .trans_fi_i   (1'b1),
        .busy         (w_busy),
        .src_ctrl     (w_src_ctrl),
        .frame_cnt    (w_frame_cnt)
    );

    typedef struct {
        logic       tx_en;
        logic       cts_n;
        logic       ctrl_req;
        logic [7:0] ctrl_data;
        logic       fifo_empty;
        logic [7:0] fifo_data;
        logic       exp_grant;
        logic       exp_src;
        logic [7:0] exp_data;
    } vec_t;

    vec_t  vecs [8];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    exp_fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        tx_en_i      = 1'b0;
        cts_n_i      = 1'b0;
        tick_i       = 1'b0;
        ctrl_req_i   = 1'b0;
        ctrl_data_i  = 8'h00;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 8'h00;
        trans_fi_i   = 1'b0;
    endtask

    task automatic finish_frame();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        exp_fcnt++;
    endtask

    task automatic run_vec(input vec_t v);
        int bad;
        tx_en_i      = v.tx_en;
        cts_n_i      = v.cts_n;
        ctrl_req_i   = v.ctrl_req;
        ctrl_data_i  = v.ctrl_data;
        fifo_empty_i = v.fifo_empty;
        fifo_data_i  = v.fifo_data;
        step();
        if (v.exp_grant) begin
            check("vec_ack", ctrl_ack, v.exp_src);
            check("vec_pop", fifo_rd_en, !v.exp_src);
            check("vec_no_early_start", start_tx, 0);
            check("vec_data", tx_data, v.exp_data);
            check("vec_src", src_ctrl, v.exp_src);
            ctrl_req_i   = 1'b0;
            fifo_empty_i = 1'b1;
            step();
            check("vec_start", start_tx, 1);
            check("vec_ack_pop_one_cycle", ctrl_ack | fifo_rd_en, 0);
            step();
            check("vec_start_one_cycle", start_tx, 0);
            check("vec_busy_wait", busy, 1);
            finish_frame();
            check("vec_idle_after_fi", busy, 0);
            check("vec_frame_cnt", frame_cnt, exp_fcnt);
            check("vec_data_hold", tx_data, v.exp_data);
        end else begin
            bad = 0;
            for (int c = 0; c < 6; c++) begin
                if (busy || ctrl_ack || fifo_rd_en || start_tx) bad++;
                step();
            end
            check("vec_no_grant", bad, 0);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        int bad;
        int k;

        //          en   cts  creq  cdata  empty fdata  grant src  data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b1, 1'b0, 8'h55};
        vecs[1] = '{1'b1, 1'b0, 1'b1, XOFF,  1'b0, 8'hA5, 1'b1, 1'b1, 8'h13};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, XON,   1'b0, 8'h66, 1'b1, 1'b1, 8'h11};
        vecs[4] = '{1'b0, 1'b0, 1'b1, XOFF,  1'b0, 8'h77, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hAA, 1'b1, 1'b0, 8'hAA};

        clear_inputs();
        guard_cfg_i  = 8'h00;
        w_tx_en      = 1'b0;
        reset        = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'h55;
        step();
        step();
        step();
        check("rst_ctrl_ack", ctrl_ack, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_start_tx", start_tx, 0);
        check("rst_busy", busy, 0);
        check("rst_src_ctrl", src_ctrl, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_cnt", frame_cnt, 0);

        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (busy || ctrl_ack || fifo_rd_en || start_tx) bad++;
        end
        check("disabled_no_pulses", bad, 0);
        clear_inputs();
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Tie: control first, then the still-pending FIFO byte.
        tx_en_i      = 1'b1;
        ctrl_req_i   = 1'b1;
        ctrl_data_i  = XOFF;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'hA5;
        step();
        check("tie_first_ack", ctrl_ack, 1);
        check("tie_first_pop", fifo_rd_en, 0);
        check("tie_first_data", tx_data, 8'h13);
        check("tie_first_src", src_ctrl, 1);
        ctrl_req_i = 1'b0;
        step();
        step();
        finish_frame();
        check("tie_idle", busy, 0);
        step();
        check("tie_second_pop", fifo_rd_en, 1);
        check("tie_second_ack", ctrl_ack, 0);
        check("tie_second_data", tx_data, 8'hA5);
        check("tie_second_src", src_ctrl, 0);
        fifo_empty_i = 1'b1;
        step();
        check("tie_second_start", start_tx, 1);
        step();
        finish_frame();
        check("tie_frame_cnt", frame_cnt, exp_fcnt);
        clear_inputs();
        step();

        // CTS held off: FIFO never popped, control still served.
        tx_en_i      = 1'b1;
        cts_n_i      = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'h77;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (busy || fifo_rd_en || start_tx) bad++;
        end
        check("cts_no_grant_100", bad, 0);
        ctrl_req_i  = 1'b1;
        ctrl_data_i = XON;
        step();
        check("cts_ctrl_ack", ctrl_ack, 1);
        check("cts_ctrl_data", tx_data, 8'h11);
        bad = fifo_rd_en ? 1 : 0;
        ctrl_req_i = 1'b0;
        step();
        check("cts_ctrl_start", start_tx, 1);
        step();
        finish_frame();
        for (int c = 0; c < 10; c++) begin
            if (fifo_rd_en || busy) bad++;
            step();
        end
        check("cts_fifo_never_popped", bad, 0);
        clear_inputs();
        step();

        // Guard time of 3 ticks, with a config change and a stray finish inside.
        guard_cfg_i  = 8'd3;
        tx_en_i      = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'h3C;
        step();
        check("guard_pop", fifo_rd_en, 1);
        step();
        step();
        finish_frame();
        check("guard_entered", busy, 1);
        guard_cfg_i = 8'd0;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("guard_tick1_busy", busy, 1);
        step();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        check("guard_stray_fi_ignored", frame_cnt, exp_fcnt);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("guard_tick2_busy", busy, 1);
        step();
        step();
        check("guard_no_tick_busy", busy, 1);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        check("guard_tick3_release", busy, 0);
        step();
        check("guard_next_pop", fifo_rd_en, 1);
        check("guard_next_no_start", start_tx, 0);
        fifo_empty_i = 1'b1;
        step();
        check("guard_next_start", start_tx, 1);
        step();
        finish_frame();
        check("guard_zero_cfg_idle", busy, 0);
        check("guard_frame_cnt", frame_cnt, exp_fcnt);
        clear_inputs();
        step();

        // Reset while waiting for frame-finish.
        tx_en_i      = 1'b1;
        fifo_empty_i = 1'b0;
        fifo_data_i  = 8'h5A;
        step();
        fifo_empty_i = 1'b1;
        step();
        step();
        check("rwait_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_fcnt = 0;
        check("rwait_idle", busy, 0);
        check("rwait_frame_cnt", frame_cnt, 0);
        check("rwait_tx_data", tx_data, 8'h00);
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        step();
        check("rwait_late_fi_ignored", frame_cnt, 0);
        check("rwait_still_idle", busy | start_tx, 0);
        clear_inputs();
        step();

        // Frame counter wrap on the narrow instance.
        w_tx_en = 1'b1;
        k = 0;
        while (w_frame_cnt != 4'hF && k < 200) begin
            step();
            k++;
        end
        check("wrap_reach_max", w_frame_cnt, 4'hF);
        k = 0;
        while (w_frame_cnt == 4'hF && k < 20) begin
            step();
            k++;
        end
        w_tx_en = 1'b0;
        check("wrap_to_zero", w_frame_cnt, 4'h0);
        step();
        step();
        step();
        step();
        step();
        check("wrap_idle_when_disabled", w_busy | w_start_tx | w_ctrl_ack | w_fifo_rd_en, 0);
        check("wrap_fifo_source", w_src_ctrl, 0);
        check("wrap_data", w_tx_data, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
